// File: rtl/single_to_int_serial.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// single_to_int_serial
//
// Iterative IEEE-754 single-precision to signed 32-bit integer converter.
// The 24-bit significand is left-aligned in a 32-bit register and shifted
// right SHIFT_STEP bits per cycle until the binary point sits below bit 0.
// The result saturates, and the overflow flag is set when it saturates.
// Out-of-range operands, NaN, Inf, zeros and values below 1.0 bypass the
// shifter and go straight to FINISH.
//
// Optional feature macro: SINGLE_TO_INT_ROUND_EN
//   undefined : truncate toward zero (C cast semantics)
//   defined   : round half to even using guard/sticky bits
//   Latency is the same in both builds.
//
// Parameters
//   SHIFT_STEP    mantissa right-shift bits per SHIFT cycle (1, 2, 4 or 8)
//
// Ports
//   clk           system clock, rising edge
//   rst           asynchronous, active-high reset
//   start         conversion request, sampled only while idle
//   single_input  IEEE-754 single operand, latched when start is accepted
//   int_output    signed result, registered, held until the next done
//   busy          high from the accept edge until the FINISH edge
//   done          one-cycle pulse, int_output/overflow valid from this cycle
//   overflow      result was saturated, valid with done
// -----------------------------------------------------------------------------
module single_to_int_serial #(
  parameter int SHIFT_STEP = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] single_input,
  output logic [31:0] int_output,
  output logic        busy,
  output logic        done,
  output logic        overflow
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_FINISH = 2'd2
  } state_t;

  // How FINISH forms the result: from the shifted magnitude, or forced.
  typedef enum logic [1:0] {
    SP_NONE    = 2'd0,  // use magnitude (zero for tiny inputs)
    SP_POS_SAT = 2'd1,  // 0x7FFFFFFF, overflow
    SP_NEG_SAT = 2'd2,  // 0x80000000, overflow
    SP_NEG_MIN = 2'd3   // 0x80000000, exact -2^31, no overflow
  } special_t;

  localparam logic [4:0] STEP = SHIFT_STEP[4:0];

  // FSM state
  state_t     r_state;
  state_t     w_state_next;

  // Datapath registers
  logic [31:0] r_mant;
  logic [4:0]  r_n;
  logic        r_sign;
  logic        r_guard;
  logic        r_sticky;
  special_t    r_special;
  logic [31:0] r_int;
  logic        r_ovf;
  logic        r_done;

  // Operand decode
  logic        w_in_sign;
  logic [7:0]  w_in_exp;
  logic [22:0] w_in_frac;
  logic        w_in_nan;
  logic        w_in_big;
  logic        w_in_normal;
  logic        w_in_half;
  logic [7:0]  w_n_init;
  logic        w_accept;
  special_t    w_special_init;

  // Shift step
  logic [4:0]  w_step_amt;
  logic [63:0] w_wide;
  logic [31:0] w_shift_mant;
  logic [31:0] w_out_bits;
  logic        w_guard_next;
  logic        w_sticky_next;

  // Result formation
  logic        w_round_up;
  logic [31:0] w_mag;
  logic [31:0] w_signed;
  logic [31:0] w_result;
  logic        w_result_ovf;

  // ---------------------------------------------------------------------------
  // Operand decode. Biased exponent E: e = E - 127.
  //   normal shift range 0 <= e <= 30  <=>  127 <= E <= 157
  //   e >= 31 <=> E >= 158;  e == -1 <=> E == 126
  // ---------------------------------------------------------------------------
  assign w_in_sign   = single_input[31];
  assign w_in_exp    = single_input[30:23];
  assign w_in_frac   = single_input[22:0];
  assign w_in_nan    = (w_in_exp == 8'd255) && (w_in_frac != 23'd0);
  assign w_in_big    = (w_in_exp >= 8'd158);
  assign w_in_normal = (w_in_exp >= 8'd127) && (w_in_exp <= 8'd157);
  assign w_in_half   = (w_in_exp == 8'd126);
  // Shift count n = 31 - e = 158 - E, in 1..31 for the normal range.
  assign w_n_init    = 8'd158 - w_in_exp;
  assign w_accept    = (r_state == ST_IDLE) && start;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path
    // leaves it unassigned; a missing default infers a latch.
    w_special_init = SP_NONE;
    if (w_in_nan) begin
      w_special_init = SP_POS_SAT;
    end else if (w_in_big) begin
      if (single_input == 32'hCF00_0000) begin
        w_special_init = SP_NEG_MIN;
      end else if (w_in_sign) begin
        w_special_init = SP_NEG_SAT;
      end else begin
        w_special_init = SP_POS_SAT;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_next = w_in_normal ? ST_SHIFT : ST_FINISH;
        end
      end
      ST_SHIFT: begin
        // This edge consumes the last of n when n <= STEP.
        if (r_n <= STEP) begin
          w_state_next = ST_FINISH;
        end
      end
      ST_FINISH: w_state_next = ST_IDLE;
      default:   w_state_next = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: output / datapath combinational logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_step_amt = (r_n < STEP) ? r_n : STEP;
    // Bits shifted out land at the top of the lower half of w_wide, so the
    // first one out of the mantissa is always w_out_bits[31] (the guard).
    w_wide        = {r_mant, 32'd0} >> w_step_amt;
    w_shift_mant  = w_wide[63:32];
    w_out_bits    = w_wide[31:0];
    w_guard_next  = w_out_bits[31];
    w_sticky_next = r_sticky | r_guard | (|w_out_bits[30:0]);

`ifdef SINGLE_TO_INT_ROUND_EN
    w_round_up = r_guard & (r_sticky | r_mant[0]);
`else
    w_round_up = 1'b0;
`endif

    // Largest normal-range magnitude is 2^31-128, so the increment cannot
    // carry into bit 31.
    w_mag    = r_mant + {31'd0, w_round_up};
    w_signed = r_sign ? (~w_mag + 32'd1) : w_mag;

    w_result     = w_signed;
    w_result_ovf = 1'b0;
    case (r_special)
      SP_POS_SAT: begin
        w_result     = 32'h7FFF_FFFF;
        w_result_ovf = 1'b1;
      end
      SP_NEG_SAT: begin
        w_result     = 32'h8000_0000;
        w_result_ovf = 1'b1;
      end
      SP_NEG_MIN: begin
        w_result     = 32'h8000_0000;
        w_result_ovf = 1'b0;
      end
      default: begin
        w_result     = w_signed;
        w_result_ovf = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mant    <= 32'd0;
      r_n       <= 5'd0;
      r_sign    <= 1'b0;
      r_guard   <= 1'b0;
      r_sticky  <= 1'b0;
      r_special <= SP_NONE;
      r_int     <= 32'd0;
      r_ovf     <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= (r_state == ST_FINISH);

      if (w_accept) begin
        r_sign    <= w_in_sign;
        r_special <= w_special_init;
        r_n       <= w_n_init[4:0];
        if (w_in_normal) begin
          r_mant   <= {1'b1, w_in_frac, 8'd0};
          r_guard  <= 1'b0;
          r_sticky <= 1'b0;
        end else begin
          // Direct-to-FINISH: magnitude is zero. For e = -1 the hidden bit is
          // exactly the guard (weight 0.5) and the fraction is the sticky.
          r_mant   <= 32'd0;
          r_guard  <= w_in_half;
          r_sticky <= w_in_half & (|w_in_frac);
        end
      end else if (r_state == ST_SHIFT) begin
        r_mant   <= w_shift_mant;
        r_n      <= r_n - w_step_amt;
        r_guard  <= w_guard_next;
        r_sticky <= w_sticky_next;
      end

      if (r_state == ST_FINISH) begin
        r_int <= w_result;
        r_ovf <= w_result_ovf;
      end
    end
  end

  assign busy       = (r_state != ST_IDLE);
  assign done       = r_done;
  assign int_output = r_int;
  assign overflow   = r_ovf;

endmodule

// File: tb/tb_single_to_int_serial.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_single_to_int_serial
//
// Scoreboard bench: each accepted operand pushes its expected result, flag and
// latency (from an arithmetic reference model) into a queue; a monitor pops and
// compares whenever done pulses. A second instance with SHIFT_STEP=1 checks the
// long-latency case. Define SINGLE_TO_INT_ROUND_EN for both RTL and bench to
// exercise the rounding build.
// -----------------------------------------------------------------------------
module tb_single_to_int_serial;

  localparam int STEP = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] single_input;
  logic [31:0] int_output;
  logic        busy;
  logic        done;
  logic        overflow;

  logic        start1;
  logic [31:0] single_input1;
  logic [31:0] int_output1;
  logic        busy1;
  logic        done1;
  logic        overflow1;

  always #5 clk = ~clk;

  single_to_int_serial #(.SHIFT_STEP(STEP)) u_dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .single_input (single_input),
    .int_output   (int_output),
    .busy         (busy),
    .done         (done),
    .overflow     (overflow)
  );

  single_to_int_serial #(.SHIFT_STEP(1)) u_dut_step1 (
    .clk          (clk),
    .rst          (rst),
    .start        (start1),
    .single_input (single_input1),
    .int_output   (int_output1),
    .busy         (busy1),
    .done         (done1),
    .overflow     (overflow1)
  );

  typedef struct {
    logic [31:0] op;
    logic [31:0] val;
    logic        ovf;
    int          lat;
    time         acc_t;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
    end
  endtask

  // Reference: value = {1,frac} * 2^(e-23); integer part plus remainder.
  function automatic exp_t model(input logic [31:0] f);
    exp_t        r;
    int          big_e;
    int          e;
    int          sh;
    logic [22:0] fr;
    longint      m;
    longint      mag;
    longint      rem;
    longint      half;
    logic [31:0] m32;
    r.op    = f;
    r.val   = 32'd0;
    r.ovf   = 1'b0;
    r.lat   = 1;
    r.acc_t = 0;
    big_e   = int'(f[30:23]);
    fr      = f[22:0];
    e       = big_e - 127;
    if (big_e == 255 && fr != 23'd0) begin
      r.val = 32'h7FFF_FFFF;
      r.ovf = 1'b1;
    end else if (e >= 31) begin
      if (f == 32'hCF00_0000) begin
        r.val = 32'h8000_0000;
      end else if (f[31]) begin
        r.val = 32'h8000_0000;
        r.ovf = 1'b1;
      end else begin
        r.val = 32'h7FFF_FFFF;
        r.ovf = 1'b1;
      end
    end else if (e >= -1) begin
      if (e >= 0) r.lat = (31 - e + STEP - 1) / STEP + 1;
      m  = longint'({1'b1, fr});
      sh = 23 - e;
      if (sh <= 0) begin
        mag  = m << (-sh);
        rem  = 0;
        half = 1;
      end else begin
        mag  = m >> sh;
        rem  = m & ((64'sd1 <<< sh) - 1);
        half = 64'sd1 <<< (sh - 1);
      end
`ifdef SINGLE_TO_INT_ROUND_EN
      if (rem > half || (rem == half && mag[0])) mag = mag + 1;
`endif
      m32   = mag[31:0];
      r.val = f[31] ? (32'd0 - m32) : m32;
    end
    return r;
  endfunction

  // Monitor: pop and compare on every done pulse.
  always @(negedge clk) begin
    exp_t x;
    int   lat;
    if (!rst && done) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_done: got done with value 0x%08h, expected no done", int_output);
      end else begin
        x   = sb.pop_front();
        lat = int'(($time - x.acc_t - 5) / 10);
        check($sformatf("value[%08h]", x.op), int_output, x.val);
        check($sformatf("ovf[%08h]", x.op), {31'd0, overflow}, {31'd0, x.ovf});
        check($sformatf("latency[%08h]", x.op), lat, x.lat);
        check($sformatf("busy_at_done[%08h]", x.op), {31'd0, busy}, 32'd0);
      end
    end
  end

  task automatic send(input logic [31:0] v);
    exp_t x;
    int   cnt;
    cnt = 0;
    @(negedge clk);
    while (busy && cnt < 100) begin
      @(negedge clk);
      cnt++;
    end
    if (busy) begin
      n_checks++;
      n_errors++;
      $display("FAIL busy_timeout: got busy=1 after %0d cycles, expected idle", cnt);
      return;
    end
    start        = 1'b1;
    single_input = v;
    @(posedge clk);
    x       = model(v);
    x.acc_t = $time;
    sb.push_back(x);
    @(negedge clk);
    check($sformatf("busy_after_accept[%08h]", v), {31'd0, busy}, 32'd1);
    start        = 1'b0;
    single_input = $urandom;
  endtask

  task automatic drain();
    int cnt;
    cnt = 0;
    while (sb.size() != 0 && cnt < 200) begin
      @(negedge clk);
      cnt++;
    end
    if (sb.size() != 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL drain_timeout: got %0d pending results, expected 0", sb.size());
      sb.delete();
    end
  endtask

  logic [31:0] directed [] = '{
    32'hC180_0000, 32'h4EFE_0000, 32'h3F80_0000, 32'hCF00_0000, 32'h4F00_0000,
    32'hFF80_0000, 32'h7FC0_0000, 32'h8000_0000, 32'h3FC0_0000, 32'h4020_0000,
    32'hBF40_0000, 32'h7F80_0000, 32'h0000_0001, 32'h3F00_0000, 32'h3F40_0000,
    32'hBF80_0000, 32'hCEFF_FFFF, 32'h4EFF_FFFF, 32'hFFC0_0001, 32'hBFC0_0000
  };

  initial begin
    exp_t        x;
    logic [31:0] r;
    time         t0;
    int          cnt;
    int          lat;

    rst           = 1'b1;
    start         = 1'b0;
    single_input  = 32'd0;
    start1        = 1'b0;
    single_input1 = 32'd0;
    repeat (3) @(negedge clk);
    check("reset_int_output", int_output, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_overflow", {31'd0, overflow}, 32'd0);
    rst = 1'b0;

    // SHIFT_STEP=1 instance: 1.0 needs 31 shift cycles, done at +32.
    @(negedge clk);
    start1        = 1'b1;
    single_input1 = 32'h3F80_0000;
    @(posedge clk);
    t0 = $time;
    @(negedge clk);
    start1 = 1'b0;
    cnt    = 0;
    while (!done1 && cnt < 100) begin
      @(negedge clk);
      cnt++;
    end
    lat = int'(($time - t0 - 5) / 10);
    check("step1_latency", lat, 32'd32);
    check("step1_value", int_output1, 32'd1);
    check("step1_ovf", {31'd0, overflow1}, 32'd0);

    // Directed vectors, issued back to back.
    foreach (directed[i]) send(directed[i]);
    drain();

    // Randomized operands, exponent mostly near the conversion range.
    for (int i = 0; i < 300; i++) begin
      r = $urandom;
      if ($urandom_range(0, 3) != 0) r[30:23] = 8'($urandom_range(120, 160));
      send(r);
    end
    drain();

    // Start pulses and operand changes while busy are ignored.
    send(32'h3F80_0000);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      start        = 1'b1;
      single_input = $urandom;
    end
    @(negedge clk);
    start = 1'b0;
    drain();

    // Start held through done: the next operand is accepted in the done cycle.
    send(32'hC180_0000);
    @(negedge clk);
    start        = 1'b1;
    single_input = 32'h4EFE_0000;
    cnt          = 0;
    while (busy && cnt < 50) begin
      @(negedge clk);
      cnt++;
    end
    check("held_start_done_cycle", {31'd0, done}, 32'd1);
    @(posedge clk);
    x       = model(32'h4EFE_0000);
    x.acc_t = $time;
    sb.push_back(x);
    @(negedge clk);
    start = 1'b0;
    drain();

    // Reset mid-SHIFT: outputs clear at once, the aborted conversion never completes.
    send(32'h3F80_0000);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midreset_int_output", int_output, 32'd0);
    check("midreset_busy", {31'd0, busy}, 32'd0);
    check("midreset_done", {31'd0, done}, 32'd0);
    check("midreset_overflow", {31'd0, overflow}, 32'd0);
    sb.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (15) @(negedge clk);
    send(32'hC180_0000);
    send(32'h3FC0_0000);
    drain();

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
